// File: rtl/ocram_pkg.sv
// Shared types for the OCRAM SRAM arbiter.
//   arb_state_e : arbitration FSM states (free rotation / locked hold)
//   sram_req_t  : one requester's access fields as presented to the macro
//   NREQ, ID_W  : number of requesters and width of a requester id
package ocram_pkg;

  localparam int NREQ         = 2;
  localparam int ID_W         = $clog2(NREQ);
  // Widest byte address the request struct carries; the top slices it down.
  localparam int OCRAM_ADDR_W = 32;

  typedef enum logic {
    ARB_FREE = 1'b0,
    ARB_HOLD = 1'b1
  } arb_state_e;

  typedef struct packed {
    logic                    we;
    logic [OCRAM_ADDR_W-1:0] addr;
    logic [7:0]              wdata;
  } sram_req_t;

endpackage

// File: rtl/ocram_rd_pipe.sv
// Read-return tracker: an RD_LAT-deep shift register of {valid, id} that
// lines up each granted read with the macro's read data.
//   clk, rstn : clock, asynchronous active-low reset (flushes in-flight reads)
//   in_vld    : a read was issued to the macro this cycle
//   in_id     : requester that issued it
//   out_vld   : read data on sram_dout belongs to a read this cycle
//   out_id    : requester that owns that data
module ocram_rd_pipe
  import ocram_pkg::*;
#(
  parameter int RD_LAT = 1
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            in_vld,
  input  logic [ID_W-1:0] in_id,
  output logic            out_vld,
  output logic [ID_W-1:0] out_id
);

  logic [RD_LAT-1:0]            vld_q, vld_d;
  logic [RD_LAT-1:0][ID_W-1:0]  id_q,  id_d;

  always_comb begin
    vld_d    = vld_q;
    id_d     = id_q;
    vld_d[0] = in_vld;
    id_d[0]  = in_id;
    for (int i = 1; i < RD_LAT; i++) begin
      vld_d[i] = vld_q[i-1];
      id_d[i]  = id_q[i-1];
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      vld_q <= '0;
      id_q  <= '0;
    end else begin
      vld_q <= vld_d;
      id_q  <= id_d;
    end
  end

  assign out_vld = vld_q[RD_LAT-1];
  assign out_id  = id_q[RD_LAT-1];

endmodule

// File: rtl/ocram_sram_arbiter.sv
// Two-requester arbiter for the byte-wide OCRAM SRAM macro.
// Round-robin between m0 (APB SRAM controller) and m1 (boot/debug port), with
// an optional lock that keeps ownership for up to MAX_HOLD consecutive grants.
//   clk, rstn              : clock, asynchronous active-low reset
//   mK_req/lock/we/addr/wdata : requester K access, held until mK_gnt
//   mK_gnt                 : access issued to the macro this cycle
//   mK_rvalid, mK_rdata    : read return, RD_LAT cycles after a read grant
//   sram_cs/we/addr/din    : macro command (combinational from the winner)
//   sram_dout              : macro read data
module ocram_sram_arbiter
  import ocram_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int RD_LAT     = 1,
  parameter int MAX_HOLD   = 8
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  m0_req,
  input  logic                  m0_lock,
  input  logic                  m0_we,
  input  logic [ADDR_WIDTH-1:0] m0_addr,
  input  logic [7:0]            m0_wdata,
  output logic                  m0_gnt,
  output logic                  m0_rvalid,
  output logic [7:0]            m0_rdata,
  input  logic                  m1_req,
  input  logic                  m1_lock,
  input  logic                  m1_we,
  input  logic [ADDR_WIDTH-1:0] m1_addr,
  input  logic [7:0]            m1_wdata,
  output logic                  m1_gnt,
  output logic                  m1_rvalid,
  output logic [7:0]            m1_rdata,
  output logic                  sram_cs,
  output logic                  sram_we,
  output logic [ADDR_WIDTH-1:0] sram_addr,
  output logic [7:0]            sram_din,
  input  logic [7:0]            sram_dout
);

  localparam logic [7:0] HOLD_LIM = 8'(MAX_HOLD);
  localparam bit         LOCK_EN  = (MAX_HOLD > 1);

  arb_state_e state_q, state_d;
  logic       pri_q, pri_d;
  logic       owner_q, owner_d;
  logic [7:0] hold_cnt_q, hold_cnt_d;

  logic       hold_act;
  logic       arb_pri;
  sram_req_t  req0, req1, sel;
  logic       rd_vld, tail_vld;
  logic [ID_W-1:0] rd_id, tail_id;

  // State register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= ARB_FREE;
      pri_q      <= 1'b0;
      owner_q    <= 1'b0;
      hold_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      pri_q      <= pri_d;
      owner_q    <= owner_d;
      hold_cnt_q <= hold_cnt_d;
    end
  end

  // Grant and macro command (output process)
  always_comb begin
    hold_act = (state_q == ARB_HOLD) &&
               (owner_q ? (m1_req & m1_lock) : (m0_req & m0_lock));
    // Once the owner lets go, the other side gets first pick that same cycle.
    arb_pri  = (state_q == ARB_HOLD) ? ~owner_q : pri_q;
    if (hold_act) begin
      m0_gnt = ~owner_q;
      m1_gnt = owner_q;
    end else begin
      m0_gnt = m0_req & (~m1_req | ~arb_pri);
      m1_gnt = m1_req & (~m0_req |  arb_pri);
    end
    // Nothing may reach the macro while reset is held.
    m0_gnt = m0_gnt & rstn;
    m1_gnt = m1_gnt & rstn;

    req0.we    = m0_we;
    req0.addr  = OCRAM_ADDR_W'(m0_addr);
    req0.wdata = m0_wdata;
    req1.we    = m1_we;
    req1.addr  = OCRAM_ADDR_W'(m1_addr);
    req1.wdata = m1_wdata;
    sel        = m1_gnt ? req1 : req0;

    sram_cs   = m0_gnt | m1_gnt;
    sram_we   = sram_cs & sel.we;
    sram_addr = sel.addr[ADDR_WIDTH-1:0];
    sram_din  = sel.wdata;
  end

  // Next-state process
  always_comb begin
    state_d    = state_q;
    pri_d      = pri_q;
    owner_d    = owner_q;
    hold_cnt_d = hold_cnt_q;
    if (hold_act) begin
      hold_cnt_d = hold_cnt_q + 8'd1;
      if ((hold_cnt_q + 8'd1) == HOLD_LIM) begin
        state_d    = ARB_FREE;
        pri_d      = ~owner_q;
        hold_cnt_d = '0;
      end
    end else begin
      // Free rotation, or the cycle the owner released its hold.
      state_d    = ARB_FREE;
      hold_cnt_d = '0;
      if (sram_cs) begin
        if (LOCK_EN && (m1_gnt ? m1_lock : m0_lock)) begin
          state_d    = ARB_HOLD;
          owner_d    = m1_gnt;
          hold_cnt_d = 8'd1;
        end else begin
          pri_d = ~m1_gnt;
        end
      end else begin
        pri_d = arb_pri;
      end
    end
  end

  assign rd_vld = sram_cs & ~sram_we;
  assign rd_id  = ID_W'(m1_gnt);

  ocram_rd_pipe #(
    .RD_LAT (RD_LAT)
  ) u_rd_pipe (
    .clk     (clk),
    .rstn    (rstn),
    .in_vld  (rd_vld),
    .in_id   (rd_id),
    .out_vld (tail_vld),
    .out_id  (tail_id)
  );

  always_comb begin
    m0_rvalid = tail_vld & (tail_id == ID_W'(0));
    m1_rvalid = tail_vld & (tail_id == ID_W'(1));
    m0_rdata  = m0_rvalid ? sram_dout : 8'h00;
    m1_rdata  = m1_rvalid ? sram_dout : 8'h00;
  end

endmodule
